// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the RV32M multiply/divide execute unit.
package mdu_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int          DIV_ITERS = 32;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_core.sv
// Unsigned restoring divider: one quotient bit per step; quotient/remainder
// outputs are the values after the current step so the caller can capture on the last one.
module div_core import mdu_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            last
);

    localparam int CNT_W = $clog2(DIV_ITERS);

    logic [XLEN-1:0]  rem_q, quo_q, dvs_q;
    logic [CNT_W-1:0] count;
    logic [XLEN:0]    shifted, trial;

    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        trial   = shifted - {1'b0, dvs_q};
        // Borrow out means the trial subtraction went negative: keep the shifted value.
        if (trial[XLEN]) begin
            remainder = shifted[XLEN-1:0];
            quotient  = {quo_q[XLEN-2:0], 1'b0};
        end else begin
            remainder = trial[XLEN-1:0];
            quotient  = {quo_q[XLEN-2:0], 1'b1};
        end
        last = (count == CNT_W'(DIV_ITERS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (step) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            rem_q <= remainder;
            quo_q <= quotient;
        end
    end

endmodule

// File: rtl/mdu_exec.sv
// RV32M execute-stage multiply/divide unit: single-pass multiply, iterative
// restoring divide, fast path for divide-by-zero and signed overflow.
module mdu_exec import mdu_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    state_t state_q, state_d;

    logic [XLEN-1:0] a_q, b_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;

    logic            accept, div_step, div_last;
    logic            in_signed, in_special;
    logic [XLEN-1:0] mag_a, mag_b, div_quot, div_rem;

    logic                   a_sgn, b_sgn, q_neg, r_neg;
    logic signed [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN-1:0]        mul_res, spec_res, fast_res, div_res;

    always_comb begin
        in_signed  = ~funct3[0];
        mag_a      = (in_signed && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
        mag_b      = (in_signed && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;
        in_special = funct3[2] && ((rs2_data == '0) ||
                     (in_signed && rs1_data == INT_MIN && rs2_data == ALL_ONES));
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        div_step = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    accept  = 1'b1;
                    state_d = (!funct3[2] || in_special) ? MUL : DIV;
                end
            end
            MUL: state_d = DONE;
            DIV: begin
                div_step = 1'b1;
                if (div_last) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        // An abort overrides everything, including a simultaneous launch.
        if (flush) begin
            state_d = IDLE;
            accept  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= rs1_data;
            b_q  <= rs2_data;
            f3_q <= funct3;
            rd_q <= rd_in;
        end
    end

    div_core #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      (div_step),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (div_quot),
        .remainder (div_rem),
        .last      (div_last)
    );

    always_comb begin
        a_sgn   = (f3_q == F3_MULH) || (f3_q == F3_MULHSU);
        b_sgn   = (f3_q == F3_MULH);
        mul_a   = {{XLEN{a_sgn & a_q[XLEN-1]}}, a_q};
        mul_b   = {{XLEN{b_sgn & b_q[XLEN-1]}}, b_q};
        prod    = mul_a * mul_b;
        mul_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

        if (b_q == '0) spec_res = f3_q[1] ? a_q : ALL_ONES;
        else           spec_res = f3_q[1] ? '0  : INT_MIN;
        fast_res = f3_q[2] ? spec_res : mul_res;

        q_neg   = ~f3_q[0] & (a_q[XLEN-1] ^ b_q[XLEN-1]);
        r_neg   = ~f3_q[0] & a_q[XLEN-1];
        div_res = f3_q[1] ? (r_neg ? -div_rem  : div_rem)
                          : (q_neg ? -div_quot : div_quot);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            rd_out <= '0;
        end else if (!flush) begin
            if (state_q == MUL) begin
                result <= fast_res;
                rd_out <= rd_q;
            end else if (state_q == DIV && div_last) begin
                result <= div_res;
                rd_out <= rd_q;
            end
        end
    end

    assign busy = (state_q == MUL) || (state_q == DIV);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_mdu_exec.sv
// Randomized and directed bench for mdu_exec against a plain-arithmetic RV32M model.
module tb_mdu_exec;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_exp;
    logic [4:0]  last_rd;

    mdu_exec #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        int ia, ib;
        ia = a;
        ib = b;
        case (f3)
            3'b000: begin p = longint'(ia) * longint'(ib); return p[31:0]; end
            3'b001: begin p = longint'(ia) * longint'(ib); return p[63:32]; end
            3'b010: begin p = longint'(ia) * longint'({32'b0, b}); return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!f3[2] || b == 0) return 2;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // Presents an op in the current cycle (cycle 0); returns #1 into cycle 1 with inputs scrambled.
    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b; rd_in = rd;
        @(posedge clk); #1;
        start = 1'b0; funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
        rd_in = 5'($urandom);
    endtask

    task automatic wait_done(input int from_cyc, output int cyc);
        cyc = from_cyc;
        while (!done && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        int cyc;
        start_op(f3, a, b, rd);
        wait_done(1, cyc);
        last_exp = ref_result(f3, a, b);
        last_rd  = rd;
        check_eq({tag, "_lat"}, cyc, ref_latency(f3, a, b));
        check_eq({tag, "_res"}, result, last_exp);
        check_eq({tag, "_rd"}, {27'b0, rd_out}, {27'b0, rd});
        check_eq({tag, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int cyc, pulses;
        logic [2:0] f3;
        logic [31:0] a, b;
        logic [4:0] rd;

        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0;
        rs1_data = '0; rs2_data = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_rd", {27'b0, rd_out}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        start_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
        check_eq("mul_busy_c1", {31'b0, busy}, 32'd1);
        wait_done(1, cyc);
        check_eq("mul_lat", cyc, 32'd2);
        check_eq("mul_res", result, 32'hFFFF_FFEB);
        check_eq("mul_rd", {27'b0, rd_out}, 32'd5);
        check_eq("mul_busy_c2", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        check_eq("done_one_cycle", {31'b0, done}, 32'd0);

        do_op("mulh", 3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1);
        check_eq("mulh_val", result, 32'h0000_0000);
        do_op("mulhsu", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2);
        check_eq("mulhsu_val", result, 32'h8000_0000);
        do_op("mulhu", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
        check_eq("mulhu_val", result, 32'h7FFF_FFFF);
        do_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4);
        check_eq("div_val", result, 32'hFFFF_FFFD);
        do_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6);
        check_eq("rem_val", result, 32'hFFFF_FFFF);
        do_op("divu", 3'b101, 32'd100, 32'd7, 5'd7);
        check_eq("divu_val", result, 32'd14);
        do_op("remu", 3'b111, 32'd100, 32'd7, 5'd8);
        check_eq("remu_val", result, 32'd2);
        do_op("div0", 3'b100, 32'd5, 32'd0, 5'd9);
        do_op("rem0", 3'b110, 32'd5, 32'd0, 5'd10);
        do_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        do_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);

        start_op(3'b100, 32'd1000, 32'd3, 5'd13);
        repeat (9) begin @(posedge clk); #1; end
        start = 1'b1; funct3 = 3'b000; rs1_data = 32'd2; rs2_data = 32'd2; rd_in = 5'd20;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(11, cyc);
        check_eq("ign_lat", cyc, 32'd33);
        check_eq("ign_res", result, 32'd333);
        check_eq("ign_rd", {27'b0, rd_out}, 32'd13);
        last_exp = 32'd333; last_rd = 5'd13;
        @(posedge clk); #1;

        start_op(3'b101, 32'd999, 32'd9, 5'd14);
        repeat (14) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("flush_busy", {31'b0, busy}, 32'd0);
        check_eq("flush_done", {31'b0, done}, 32'd0);
        check_eq("flush_res", result, last_exp);
        check_eq("flush_rd", {27'b0, rd_out}, {27'b0, last_rd});
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (done) pulses++; end
        check_eq("flush_no_done", pulses, 32'd0);

        start = 1'b1; flush = 1'b1; funct3 = 3'b000;
        rs1_data = 32'd3; rs2_data = 32'd3; rd_in = 5'd15;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check_eq("sf_busy", {31'b0, busy}, 32'd0);
        pulses = 0;
        repeat (5) begin @(posedge clk); #1; if (done) pulses++; end
        check_eq("sf_no_done", pulses, 32'd0);
        check_eq("sf_res", result, last_exp);

        start_op(3'b100, 32'hFFFF_FF00, 32'd16, 5'd16);
        wait_done(1, cyc);
        check_eq("b2b_div_lat", cyc, 32'd33);
        check_eq("b2b_div_res", result, 32'hFFFF_FFF0);
        start_op(3'b000, 32'd6, 32'd7, 5'd17);
        check_eq("b2b_busy", {31'b0, busy}, 32'd1);
        wait_done(1, cyc);
        check_eq("b2b_mul_lat", cyc, 32'd2);
        check_eq("b2b_mul_res", result, 32'd42);
        check_eq("b2b_mul_rd", {27'b0, rd_out}, 32'd17);

        start_op(3'b110, 32'd12345, 32'd11, 5'd18);
        repeat (8) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("mrst_busy", {31'b0, busy}, 32'd0);
        check_eq("mrst_done", {31'b0, done}, 32'd0);
        check_eq("mrst_res", result, 32'd0);
        check_eq("mrst_rd", {27'b0, rd_out}, 32'd0);
        pulses = 0;
        repeat (30) begin @(posedge clk); #1; if (done) pulses++; end
        check_eq("mrst_no_done", pulses, 32'd0);

        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom);
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom);
            do_op("rand", f3, a, b, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
